// File: rtl/paddle_ctl.sv
// Paddle controller: clamped, frame-synchronous paddle position (direct or slew-limited),
// ball hold/launch FSM and timed wide-paddle power-up. All outputs registered, 1-cycle latency; no backpressure.
module paddle_ctl #(
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 1023,
   parameter int Y_POS       = 748,
   parameter int X_START     = 412,
   parameter int W_NORM      = 200,
   parameter int W_WIDE      = 300,
   parameter int MAX_STEP    = 16,
   parameter int WIDE_FRAMES = 600
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [11:0] mouse_xpos,
   input  logic        mouse_left,
   input  logic        mode,
   input  logic        freeze,
   input  logic        ball_lost,
   input  logic        wide_req,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic [11:0] paddle_w,
   output logic        ball_held,
   output logic        launch,
   output logic        wide_active
);

   localparam logic [11:0] XMIN_C   = 12'(X_MIN);
   localparam logic [11:0] XMAX1_C  = 12'(X_MAX + 1);
   localparam logic [11:0] YPOS_C   = 12'(Y_POS);
   localparam logic [11:0] XSTART_C = 12'(X_START);
   localparam logic [11:0] WNORM_C  = 12'(W_NORM);
   localparam logic [11:0] WWIDE_C  = 12'(W_WIDE);
   localparam logic [11:0] STEP_C   = 12'(MAX_STEP);
   localparam logic [11:0] WFR_C    = 12'(WIDE_FRAMES);

   typedef enum logic {HOLD, PLAY} state_t;

   state_t      state_q;
   state_t      state_nxt;
   logic        launch_nxt;
   logic        btn_d;
   logic        rise;
   logic        move;
   logic [11:0] wide_cnt;
   logic [11:0] x_hi;
   logic [11:0] target;
   logic [11:0] cur;
   logic [11:0] x_nxt;

   assign rise = mouse_left & ~btn_d;
   assign move = frame_tick & ~freeze;

   // A paddle that no longer fits (width grew) is pulled inside the range first;
   // only motion beyond that correction is slew-limited.
   always_comb begin
      x_hi   = XMAX1_C - paddle_w;
      target = mouse_xpos;
      if (mouse_xpos < XMIN_C) begin
         target = XMIN_C;
      end else if (mouse_xpos > x_hi) begin
         target = x_hi;
      end
      cur   = (xpos > x_hi) ? x_hi : xpos;
      x_nxt = target;
      if (mode) begin
         if (target > cur + STEP_C) begin
            x_nxt = cur + STEP_C;
         end else if (cur > target + STEP_C) begin
            x_nxt = cur - STEP_C;
         end
      end
   end

   always_comb begin
      state_nxt  = state_q;
      launch_nxt = 1'b0;
      case (state_q)
         HOLD: begin
            if (rise && !freeze) begin
               state_nxt  = PLAY;
               launch_nxt = 1'b1;
            end
         end
         PLAY: begin
            if (ball_lost) begin
               state_nxt = HOLD;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q   <= HOLD;
         btn_d     <= 1'b1;
         ball_held <= 1'b1;
         launch    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         btn_d     <= mouse_left;
         ball_held <= (state_nxt == HOLD);
         launch    <= launch_nxt;
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         xpos <= XSTART_C;
         ypos <= YPOS_C;
      end else begin
         ypos <= YPOS_C;
         if (move) begin
            xpos <= x_nxt;
         end
      end
   end

   // Priority: ball_lost clears, then wide_req reloads, then frame decrement.
   always_ff @(posedge pclk) begin
      if (reset) begin
         wide_cnt    <= '0;
         wide_active <= 1'b0;
         paddle_w    <= WNORM_C;
      end else if (ball_lost) begin
         wide_cnt    <= '0;
         wide_active <= 1'b0;
         paddle_w    <= WNORM_C;
      end else if (wide_req) begin
         wide_cnt    <= WFR_C;
         wide_active <= 1'b1;
         paddle_w    <= WWIDE_C;
      end else if (wide_active && move) begin
         wide_cnt <= wide_cnt - 12'd1;
         if (wide_cnt == 12'd1) begin
            wide_active <= 1'b0;
            paddle_w    <= WNORM_C;
         end
      end
   end

endmodule
